// File: rtl/delay_pipe_ctrl_if.sv
// Control/status bundle between delay_pipe_ctrl and its environment.
// Handshakes: a sample moves only in a cycle where valid and ready are both high; ready never depends on valid.
interface delay_pipe_ctrl_if #(
  parameter int CNT_W = 10
);
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic             enable;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output start, abort, in_valid, out_ready,
    input  in_ready, out_valid, enable, busy, done, in_cnt, out_cnt
  );

  modport slave (
    input  start, abort, in_valid, out_ready,
    output in_ready, out_valid, enable, busy, done, in_cnt, out_cnt
  );
endinterface

// File: rtl/delay_pipe_ctrl.sv
// Frame controller for an external enable-gated register chain: tracks stage
// occupancy with valid bits, applies back-pressure and counts samples per frame.
module delay_pipe_ctrl #(
  parameter int N_CLOCKs  = 12,
  parameter int FRAME_LEN = 784,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             resetn,
  delay_pipe_ctrl_if.slave bus,
  output logic [1:0]       o_dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FL = CNT_W'(FRAME_LEN);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_CLOCKs-1:0] r_vbits;
  logic [CNT_W-1:0]    r_in_cnt;
  logic [CNT_W-1:0]    r_out_cnt;
  logic [CNT_W-1:0]    w_in_cnt_nxt;
  logic [CNT_W-1:0]    w_out_cnt_nxt;
  logic                w_active;
  logic                w_enable;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_deliver;
  logic                w_clear;

  // The chain only stalls when its last stage is full and downstream refuses it.
  assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_enable   = w_active && (!r_vbits[N_CLOCKs-1] || bus.out_ready);
  assign w_in_ready = w_enable && (r_state == S_RUN) && (r_in_cnt < FL);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_deliver  = r_vbits[N_CLOCKs-1] && bus.out_ready;

  assign w_in_cnt_nxt  = (w_accept && (r_in_cnt < FL)) ? r_in_cnt + CNT_W'(1) : r_in_cnt;
  assign w_out_cnt_nxt = (w_deliver && (r_out_cnt < FL)) ? r_out_cnt + CNT_W'(1) : r_out_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
          w_clear     = 1'b1;
        end
      end
      S_RUN:   if (w_in_cnt_nxt == FL) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_out_cnt_nxt == FL) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides everything, including a start seen in IDLE.
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_clear     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_vbits   <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_vbits   <= '0;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_enable) r_vbits <= {r_vbits[N_CLOCKs-2:0], w_accept};
        r_in_cnt  <= w_in_cnt_nxt;
        r_out_cnt <= w_out_cnt_nxt;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vbits[N_CLOCKs-1];
  assign bus.enable    = w_enable;
  assign bus.busy      = w_active;
  assign bus.done      = (r_state == S_DONE);
  assign bus.in_cnt    = r_in_cnt;
  assign bus.out_cnt   = r_out_cnt;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_delay_pipe_ctrl.sv
// Bench for delay_pipe_ctrl: drives directed frames, models the controlled data
// chain externally and scoreboards delivered samples against accepted ones.
module tb_delay_pipe_ctrl;
  localparam int N  = 4;
  localparam int FL = 8;
  localparam int CW = 4;
  localparam int DW = 8;

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic [1:0]    dbg_state;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] chain [N];
  logic [DW-1:0] exp_q [$];
  int            n_cmp  = 0;
  int            n_err  = 0;
  int            n_dlv  = 0;
  int            n_done = 0;

  delay_pipe_ctrl_if #(.CNT_W(CW)) bus ();

  delay_pipe_ctrl #(
    .N_CLOCKs (N),
    .FRAME_LEN(FL),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required end of run");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (bus.done) n_done++;
    if (bus.out_valid && bus.out_ready) begin
      n_dlv++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dlv_extra: got delivery 0x%0h, required none (queue empty)", chain[N-1]);
      end else begin
        check("dlv_data", 32'(chain[N-1]), 32'(exp_q.pop_front()));
      end
    end
    if (bus.in_valid && bus.in_ready) exp_q.push_back(in_data);
    if (bus.enable) begin
      for (int i = N - 1; i > 0; i--) chain[i] = chain[i-1];
      chain[0] = (bus.in_valid && bus.in_ready) ? in_data : '0;
    end
  end

  // ---------------- driver ----------------
  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  // Issues start, then plays per-cycle patterns (bit k = cycle k after start
  // edge) and compares recorded output traces with hand-computed ones.
  task automatic run_frame(input string name, input int ncyc, input int run_id,
                           input logic [31:0] iv_pat, input logic [31:0] or_pat,
                           input logic [31:0] st_pat, input logic [31:0] ab_pat,
                           input logic [31:0] exp_ov, input logic [31:0] exp_ir,
                           input logic [31:0] exp_en, input logic [31:0] exp_bz,
                           input logic [31:0] exp_dn, input int exp_dlv);
    logic [31:0] ov, ir, en, bz, dn;
    int dlv0, done0;
    ov = '0; ir = '0; en = '0; bz = '0; dn = '0;
    dlv0  = n_dlv;
    done0 = n_done;
    idle_inputs();
    bus.start = 1'b1;
    tick();
    for (int k = 0; k < ncyc; k++) begin
      bus.in_valid  = iv_pat[k];
      bus.out_ready = or_pat[k];
      bus.start     = st_pat[k];
      bus.abort     = ab_pat[k];
      in_data       = DW'((run_id << 5) | k);
      @(negedge clk);
      ov[k] = bus.out_valid;
      ir[k] = bus.in_ready;
      en[k] = bus.enable;
      bz[k] = bus.busy;
      dn[k] = bus.done;
      tick();
      if (ab_pat[k]) exp_q.delete();
    end
    idle_inputs();
    check({name, "_out_valid"},  ov, exp_ov);
    check({name, "_in_ready"},   ir, exp_ir);
    check({name, "_enable"},     en, exp_en);
    check({name, "_busy"},       bz, exp_bz);
    check({name, "_done"},       dn, exp_dn);
    check({name, "_deliveries"}, 32'(n_dlv - dlv0), 32'(exp_dlv));
    check({name, "_done_count"}, 32'(n_done - done0), 32'($countones(exp_dn)));
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_end_state"},  32'(dbg_state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) chain[i] = '0;
    idle_inputs();
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", {bus.enable, bus.in_ready, bus.out_valid, bus.busy, bus.done},
          5'b00000);
    check("reset_counts", {bus.in_cnt, bus.out_cnt, dbg_state}, '0);
    tick();
    resetn = 1'b1;
    tick();

    // Clean frame; starts in RUN (k2) and DONE (k12) must be ignored.
    run_frame("basic", 14, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1004, 32'h0,
              32'h0000_0FF0, 32'h0000_00FF, 32'h0000_0FFF, 32'h0000_0FFF,
              32'h0000_1000, 8);
    check("basic_in_cnt",  32'(bus.in_cnt),  32'd8);
    check("basic_out_cnt", 32'(bus.out_cnt), 32'd8);

    // Downstream stall for k5..k9 while out_valid is high.
    run_frame("stall", 20, 2, 32'hFFFF_FFFF, 32'hFFFF_FC1F, 32'h0, 32'h0,
              32'h0001_FFF0, 32'h0000_1C1F, 32'h0001_FC1F, 32'h0001_FFFF,
              32'h0002_0000, 8);

    // Bubbles every other cycle.
    run_frame("bubble", 22, 3, 32'h5555_5555, 32'hFFFF_FFFF, 32'h0, 32'h0,
              32'h0005_5550, 32'h0000_7FFF, 32'h0007_FFFF, 32'h0007_FFFF,
              32'h0008_0000, 8);

    // Abort after three acceptances.
    run_frame("abort", 8, 4, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0, 32'h0000_0008,
              32'h0, 32'h0000_000F, 32'h0000_000F, 32'h0000_000F, 32'h0, 0);
    check("abort_in_cnt",  32'(bus.in_cnt),  32'd0);
    check("abort_out_cnt", 32'(bus.out_cnt), 32'd0);

    run_frame("post_abort", 14, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
              32'h0000_0FF0, 32'h0000_00FF, 32'h0000_0FFF, 32'h0000_0FFF,
              32'h0000_1000, 8);

    // Start together with abort in IDLE stays in IDLE.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    idle_inputs();
    @(negedge clk);
    check("start_abort_state", 32'(dbg_state), 32'd0);
    check("start_abort_busy",  32'(bus.busy),  32'd0);
    tick();

    // Reset asserted in the middle of DRAIN, observed without a clock edge.
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_data = DW'((6 << 5) | k);
      tick();
    end
    check("pre_reset_state", 32'(dbg_state), 32'd2);
    resetn = 1'b0;
    #1;
    check("async_reset_outputs",
          {bus.enable, bus.in_ready, bus.out_valid, bus.busy, bus.done}, 5'b00000);
    check("async_reset_counts", {bus.in_cnt, bus.out_cnt, dbg_state}, '0);
    exp_q.delete();
    idle_inputs();
    tick();
    tick();
    resetn = 1'b1;
    tick();
    @(negedge clk);
    check("post_reset_idle", {30'd0, dbg_state}, 32'd0);
    tick();

    run_frame("post_reset", 14, 7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
              32'h0000_0FF0, 32'h0000_00FF, 32'h0000_0FFF, 32'h0000_0FFF,
              32'h0000_1000, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
